psum_accum_ctrl: RTL and testbench
==================================

Name: psum_accum_ctrl

Overview:
- Parametrised read-modify-write controller for the partial-sum SRAM, sitting between the corelet output FIFO and the dual-address psum SRAM.
- Replaces the fixed `num_inp` address wrap with a runtime base and length.
- Adds overwrite/accumulate modes, per-lane signed saturation, and a flow-controlled readout path with optional ReLU.

Parameters:
- col, 8, number of psum lanes per SRAM word
- psum_bw, 16, signed width of each lane
- addr_w, 11, SRAM address width (depth 2^addr_w)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin accumulate pass; sampled in IDLE only
- acc  in  1  1 = add to stored psum, 0 = overwrite; latched at start
- relu  in  1  apply ReLU on readout; latched at rd_req
- base  in  addr_w  first SRAM address; latched at start/rd_req
- len  in  addr_w  vectors per pass; latched; 0 = request ignored
- in_valid  in  1  OFIFO word available
- in_data  in  col*psum_bw  OFIFO word, lane 0 in LSBs
- in_ready  out  1  pop OFIFO (beat = in_valid & in_ready)
- rd_req  in  1  begin readout pass; sampled in IDLE only
- out_valid  out  1  readout word valid
- out_data  out  col*psum_bw  readout word
- out_ready  in  1  consumer accepts
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at pass completion
- sram_cen  out  1  active-low chip enable
- sram_ren  out  1  active-low read enable
- sram_wen  out  1  active-low write enable
- sram_ra  out  addr_w  read address
- sram_wa  out  addr_w  write address
- sram_d  out  col*psum_bw  write data
- sram_q  in  col*psum_bw  read data, valid one cycle after read issue

Behaviour:
- Reset (reset == 0 at posedge):
  - state = IDLE.
  - in_ready, out_valid, busy, done = 0.
  - sram_cen, sram_ren, sram_wen = 1.
  - Addresses and data = 0.
  - Pipeline and skid registers cleared.
  - Any in-flight write is dropped.
  - Applies mid-pass with the same result.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - start with len != 0 -> ACCUM.
  - Otherwise rd_req with len != 0 -> DRAIN.
  - start and rd_req in the same cycle: start wins.
  - Requests with len == 0: ignored, no done pulse.
- ACCUM:
  - in_ready = 1 while issued beats < len.
  - Beat k, cycle t: sram_ra = (base+k) mod 2^addr_w, sram_ren = 0.
  - Cycle t+1, each lane: sum = acc ? sat(sram_q_lane + in_data_lane) : in_data_lane; sram_wa = the same address, sram_wen = 0, sram_d = sum.
  - One beat per cycle sustained. Concurrent read (beat k+1) and write (beat k) target different addresses.
  - sat: signed add in psum_bw+1 bits, clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - done pulses in the cycle after the final write is issued; FSM then returns to IDLE.
  - rd_req during ACCUM is ignored.
- DRAIN:
  - Reads len words starting at base, with address wrap mod 2^addr_w.
  - Read issued only when the 2-entry output skid buffer has a free slot, counting the read in flight.
  - Each lane output = relu ? max(lane, 0) : lane.
  - out_valid holds until out_ready; out_data stable while stalled.
  - With out_ready held high: one word per cycle, first out_valid 2 cycles after rd_req is accepted.
  - done pulses in the cycle the last word is accepted; FSM then returns to IDLE.
- sram_cen = 0 whenever sram_ren or sram_wen is 0.
- No read-after-write hazard exists within a pass: addresses are distinct. The next pass starts only after done, after the final write.

Test Plan:
- Overwrite pass: base=0, len=4, acc=0, in lanes = k+1 for beat k -> 4 writes at addresses 0..3, done once; readout gives words of 1,2,3,4.
- Accumulate pass: repeat the above with acc=1, same data -> readout 2,4,6,8; sustained in_ready = 1 for 4 consecutive cycles.
- Saturation: stored lane 0x7FF0 plus input 0x0020 -> 0x7FFF; stored 0x8010 plus input 0xFFE0 -> 0x8000.
- Wrap and ReLU: base=2046, len=4 -> addresses 2046, 2047, 0, 1; readout with relu=1 turns lane -5 into 0 and leaves +7 unchanged.
- Backpressure: out_ready toggling 1,0,0,1,... during an 8-word drain -> no word lost or duplicated, out_data stable while stalled, done on the 8th acceptance.
- Reset mid-ACCUM after 2 beats -> next cycle all outputs at reset values, no SRAM write; start + rd_req together in IDLE -> ACCUM.

Source files
------------

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: read-modify-write controller for the partial-sum SRAM.
// Accumulates OFIFO words into a base/len address window and drains it through a 2-deep skid buffer.
module psum_accum_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_w  = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     acc,
  input  logic                     relu,
  input  logic [addr_w-1:0]        base,
  input  logic [addr_w-1:0]        len,
  input  logic                     in_valid,
  input  logic [col*psum_bw-1:0]   in_data,
  output logic                     in_ready,
  input  logic                     rd_req,
  output logic                     out_valid,
  output logic [col*psum_bw-1:0]   out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_cen,
  output logic                     sram_ren,
  output logic                     sram_wen,
  output logic [addr_w-1:0]        sram_ra,
  output logic [addr_w-1:0]        sram_wa,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q
);
  localparam int W = col * psum_bw;
  localparam logic [addr_w-1:0]  ADDR_ONE = addr_w'(1);
  localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
  state_t state_q, state_d;

  logic [addr_w-1:0] base_q, base_d, len_q, len_d, cnt_q, cnt_d, acpt_q, acpt_d;
  logic              acc_q, acc_d, relu_q, relu_d;
  logic              wr_pend_q, wr_pend_d;
  logic [addr_w-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]      wr_data_q, wr_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic [W-1:0]      skid_q [2];
  logic [W-1:0]      skid_d [2];
  logic              skid_head_q, skid_head_d, skid_tail_q, skid_tail_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic              done_q, done_d;

  logic              accept_ready, beat, issue, skid_valid, pop, last_pop;
  logic [2:0]        occupancy;
  logic [W-1:0]      sum_word, relu_word;

  assign accept_ready = (state_q == ACCUM) && (cnt_q != len_q);
  assign beat         = accept_ready && in_valid;
  assign skid_valid   = (skid_cnt_q != 2'd0);
  assign pop          = skid_valid && out_ready;
  assign last_pop     = pop && (acpt_q == len_q - ADDR_ONE);
  // Slots in use after this cycle's pop, counting the word still coming back from the SRAM.
  assign occupancy    = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue        = (state_q == DRAIN) && (cnt_q != len_q) && (occupancy < 3'd2);

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic [psum_bw-1:0] old_lane, in_lane, sum_lane;
    logic [psum_bw:0]   wide_sum;
    assign old_lane = sram_q[gi*psum_bw +: psum_bw];
    assign in_lane  = wr_data_q[gi*psum_bw +: psum_bw];
    assign wide_sum = {old_lane[psum_bw-1], old_lane} + {in_lane[psum_bw-1], in_lane};
    always_comb begin
      sum_lane = in_lane;
      if (acc_q) begin
        if (wide_sum[psum_bw] != wide_sum[psum_bw-1]) begin
          sum_lane = wide_sum[psum_bw] ? LANE_MIN : LANE_MAX;
        end else begin
          sum_lane = wide_sum[psum_bw-1:0];
        end
      end
    end
    assign sum_word[gi*psum_bw +: psum_bw]  = sum_lane;
    assign relu_word[gi*psum_bw +: psum_bw] =
      (relu_q && old_lane[psum_bw-1]) ? '0 : old_lane;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d = ACCUM;
        end else if (rd_req && (len != '0)) begin
          state_d = DRAIN;
        end
      end
      ACCUM: begin
        if (wr_pend_q && (cnt_q == len_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    base_d      = base_q;
    len_d       = len_q;
    acc_d       = acc_q;
    relu_d      = relu_q;
    cnt_d       = cnt_q;
    acpt_d      = acpt_q;
    wr_pend_d   = beat;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_pend_d   = issue;
    skid_d      = skid_q;
    skid_head_d = skid_head_q;
    skid_tail_d = skid_tail_q;
    skid_cnt_d  = skid_cnt_q + {1'b0, rd_pend_q} - {1'b0, pop};
    if (state_q == IDLE) begin
      cnt_d  = '0;
      acpt_d = '0;
      if (start && (len != '0)) begin
        base_d = base;
        len_d  = len;
        acc_d  = acc;
      end else if (rd_req && (len != '0)) begin
        base_d = base;
        len_d  = len;
        relu_d = relu;
      end
    end
    if (beat) begin
      cnt_d     = cnt_q + ADDR_ONE;
      wr_addr_d = base_q + cnt_q;
      wr_data_d = in_data;
    end
    if (issue) begin
      cnt_d = cnt_q + ADDR_ONE;
    end
    if (rd_pend_q) begin
      skid_d[skid_tail_q] = relu_word;
      skid_tail_d         = ~skid_tail_q;
    end
    if (pop) begin
      skid_head_d = ~skid_head_q;
      acpt_d      = acpt_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      base_q      <= '0;
      len_q       <= '0;
      acc_q       <= 1'b0;
      relu_q      <= 1'b0;
      cnt_q       <= '0;
      acpt_q      <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_pend_q   <= 1'b0;
      skid_q[0]   <= '0;
      skid_q[1]   <= '0;
      skid_head_q <= 1'b0;
      skid_tail_q <= 1'b0;
      skid_cnt_q  <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      relu_q      <= relu_d;
      cnt_q       <= cnt_d;
      acpt_q      <= acpt_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_pend_q   <= rd_pend_d;
      skid_q      <= skid_d;
      skid_head_q <= skid_head_d;
      skid_tail_q <= skid_tail_d;
      skid_cnt_q  <= skid_cnt_d;
      done_q      <= done_d;
    end
  end

  // The write of a beat is issued the cycle after its read; a reset in that cycle suppresses it.
  always_comb begin
    in_ready  = accept_ready;
    busy      = (state_q != IDLE);
    done      = done_q || last_pop;
    out_valid = skid_valid;
    out_data  = skid_valid ? skid_q[skid_head_q] : '0;
    sram_ren  = !(beat || issue);
    sram_ra   = (beat || issue) ? (base_q + cnt_q) : '0;
    sram_wen  = !(wr_pend_q && reset);
    sram_wa   = wr_pend_q ? wr_addr_q : '0;
    sram_d    = wr_pend_q ? sum_word : '0;
    sram_cen  = sram_ren && sram_wen;
  end

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: randomized bench for psum_accum_ctrl against a lane-level array model of the psum SRAM.
module tb_psum_accum_ctrl;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int AW  = 11;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic reset, start, acc, relu, in_valid, in_ready, rd_req, out_valid, out_ready;
  logic busy, done, sram_cen, sram_ren, sram_wen;
  logic [AW-1:0] base, len, sram_ra, sram_wa;
  logic [127:0] in_data, out_data, sram_d, sram_q;

  psum_accum_ctrl #(.col(COL), .psum_bw(BW), .addr_w(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .acc(acc), .relu(relu),
    .base(base), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .rd_req(rd_req), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done),
    .sram_cen(sram_cen), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_ra(sram_ra), .sram_wa(sram_wa), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  // SRAM behavioural model and write log
  logic [127:0] mem [DEPTH];
  int           log_wa[$];
  logic [127:0] log_wd[$];
  always @(posedge clk) begin
    if (!sram_cen && !sram_wen) begin
      mem[sram_wa] <= sram_d;
      log_wa.push_back(int'(sram_wa));
      log_wd.push_back(sram_d);
    end
    if (!sram_cen && !sram_ren) sram_q <= mem[sram_ra];
  end

  // Reference model: signed lane values per address
  int           ref_mem [DEPTH][COL];
  int           exp_wa[$];
  logic [127:0] exp_wd[$];
  logic [127:0] beat_q[$];
  logic [127:0] got_words[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int lane_of(input logic [127:0] w, input int l);
    logic [15:0] x;
    x = w[l*16 +: 16];
    return int'($signed(x));
  endfunction

  function automatic logic [127:0] splat(input int v);
    logic [127:0] w;
    for (int l = 0; l < COL; l++) w[l*16 +: 16] = v[15:0];
    return w;
  endfunction

  function automatic logic [127:0] rand_word();
    logic [127:0] w;
    for (int l = 0; l < COL; l++) w[l*16 +: 16] = 16'($urandom_range(0, 65535));
    return w;
  endfunction

  task automatic accum_pass(input int b, input int n, input bit a, input bit gappy,
                            input bit with_rd, output int max_run);
    int k, cyc, run, dcnt, addr, v;
    logic [127:0] nw;
    exp_wa.delete(); exp_wd.delete(); log_wa.delete(); log_wd.delete();
    for (k = 0; k < n; k++) begin
      addr = (b + k) % DEPTH;
      nw = '0;
      for (int l = 0; l < COL; l++) begin
        v = lane_of(beat_q[k], l);
        if (a) v = sat16(ref_mem[addr][l] + v);
        ref_mem[addr][l] = v;
        nw[l*16 +: 16] = v[15:0];
      end
      exp_wa.push_back(addr);
      exp_wd.push_back(nw);
    end
    @(negedge clk);
    start = 1'b1; rd_req = with_rd; acc = a; base = AW'(b); len = AW'(n);
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0; acc = 1'b0;
    #1 check("accum_entered", {busy, in_ready, out_valid}, 3'b110);
    k = 0; cyc = 0; run = 0; max_run = 0;
    while (k < n && cyc < 300) begin
      in_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = beat_q[k];
      #1;
      if (in_ready) begin
        run++;
        if (run > max_run) max_run = run;
      end else run = 0;
      if (in_valid && in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_data = '0;
    check("accum_beats", k, n);
    #1 check("inrdy_low", in_ready, 0);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (done) dcnt++;
      @(negedge clk);
    end
    check("accum_done_cnt", dcnt, 1);
    check("accum_idle", busy, 0);
    check("wr_count", log_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < log_wa.size(); i++) begin
      check("wr_addr", log_wa[i], exp_wa[i]);
      check("wr_data", log_wd[i], exp_wd[i]);
    end
  endtask

  task automatic drain_pass(input int b, input int n, input bit r, input int mode);
    logic [127:0] expw[$];
    logic [127:0] prev, w;
    bit stalled;
    int got, cyc, first, dcnt, v, addr;
    for (int k = 0; k < n; k++) begin
      addr = (b + k) % DEPTH;
      for (int l = 0; l < COL; l++) begin
        v = ref_mem[addr][l];
        if (r && v < 0) v = 0;
        w[l*16 +: 16] = v[15:0];
      end
      expw.push_back(w);
    end
    got_words.delete();
    @(negedge clk);
    rd_req = 1'b1; relu = r; base = AW'(b); len = AW'(n);
    @(negedge clk);
    rd_req = 1'b0; relu = 1'b0;
    got = 0; cyc = 0; first = -1; dcnt = 0; stalled = 1'b0; prev = '0;
    while (got < n && cyc < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (done) dcnt++;
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (stalled) check("stall_hold", out_data, prev);
        if (out_ready) begin
          check("rd_word", out_data, expw[got]);
          got_words.push_back(out_data);
          got++;
          if (got == n) check("done_on_last", done, 1);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("rd_count", got, n);
    if (mode == 0) check("rd_latency", first, 2);
    for (int i = 0; i < 3; i++) begin
      #1;
      if (done) dcnt++;
      if (out_valid) check("rd_extra_word", out_valid, 0);
      @(negedge clk);
    end
    check("drain_done_cnt", dcnt, 1);
    check("drain_idle", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {in_ready, out_valid, busy, done}, 4'b0000);
    check({tag, "_sram_en"}, {sram_cen, sram_ren, sram_wen}, 3'b111);
    check({tag, "_addr"}, {sram_ra, sram_wa}, 22'd0);
    check({tag, "_data"}, sram_d, 128'd0);
    check({tag, "_out"}, out_data, 128'd0);
  endtask

  initial begin
    int run, b, n, mode;
    bit a, r;
    logic [127:0] w, t;
    logic [15:0] lane;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      for (int l = 0; l < COL; l++) ref_mem[i][l] = 0;
    end
    sram_q = '0;
    reset = 1'b0; start = 1'b0; acc = 1'b0; relu = 1'b0; base = '0; len = '0;
    in_valid = 1'b0; in_data = '0; rd_req = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // zero-length requests are ignored
    start = 1'b1; len = '0; base = AW'(5);
    @(negedge clk);
    start = 1'b0; rd_req = 1'b1;
    #1 check("len0_start", {busy, in_ready, done}, 3'b000);
    @(negedge clk);
    rd_req = 1'b0;
    #1 check("len0_rdreq", {busy, out_valid, done}, 3'b000);

    // overwrite pass then readout 1..4
    beat_q.delete();
    for (int k = 0; k < 4; k++) beat_q.push_back(splat(k + 1));
    accum_pass(0, 4, 1'b0, 1'b0, 1'b0, run);
    drain_pass(0, 4, 1'b0, 0);
    for (int k = 0; k < got_words.size(); k++) check("ow_word", got_words[k], splat(k + 1));

    // accumulate the same data -> 2,4,6,8 with sustained in_ready
    accum_pass(0, 4, 1'b1, 1'b0, 1'b0, run);
    check("inrdy_run", run, 4);
    drain_pass(0, 4, 1'b0, 0);
    for (int k = 0; k < got_words.size(); k++) check("acc_word", got_words[k], splat(2 * (k + 1)));

    // saturation on lane 0 in both directions
    beat_q.delete();
    w = rand_word(); w[15:0] = 16'h7FF0; beat_q.push_back(w);
    w = rand_word(); w[15:0] = 16'h8010; beat_q.push_back(w);
    accum_pass(10, 2, 1'b0, 1'b0, 1'b0, run);
    beat_q.delete();
    w = rand_word(); w[15:0] = 16'h0020; beat_q.push_back(w);
    w = rand_word(); w[15:0] = 16'hFFE0; beat_q.push_back(w);
    accum_pass(10, 2, 1'b1, 1'b0, 1'b0, run);
    drain_pass(10, 2, 1'b0, 0);
    if (got_words.size() == 2) begin
      t = got_words[0]; lane = t[15:0]; check("sat_pos", lane, 16'h7FFF);
      t = got_words[1]; lane = t[15:0]; check("sat_neg", lane, 16'h8000);
    end

    // address wrap and ReLU
    beat_q.delete();
    for (int k = 0; k < 4; k++) begin
      for (int l = 0; l < COL; l++) begin
        b = (l % 2 == 1) ? 7 : -5;
        w[l*16 +: 16] = b[15:0];
      end
      beat_q.push_back(w);
    end
    accum_pass(2046, 4, 1'b0, 1'b0, 1'b0, run);
    if (log_wa.size() == 4) check("wrap_addr", {log_wa[1][10:0], log_wa[2][10:0]}, {11'd2047, 11'd0});
    drain_pass(2046, 4, 1'b1, 0);
    if (got_words.size() == 4) begin
      t = got_words[2]; lane = t[15:0]; check("relu_neg", lane, 16'd0);
      lane = t[31:16]; check("relu_pos", lane, 16'd7);
    end

    // backpressure: 1,0,0,1 pattern over an 8-word drain
    beat_q.delete();
    for (int k = 0; k < 8; k++) beat_q.push_back(rand_word());
    accum_pass(300, 8, 1'b0, 1'b1, 1'b0, run);
    drain_pass(300, 8, 1'b0, 1);

    // randomized passes
    for (int p = 0; p < 8; p++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 10);
      a = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      beat_q.delete();
      for (int k = 0; k < n; k++) beat_q.push_back(rand_word());
      accum_pass(b, n, a, 1'b1, 1'b0, run);
      drain_pass(b, n, r, mode);
    end

    // reset in the middle of an accumulate pass
    log_wa.delete(); log_wd.delete();
    w = rand_word(); t = rand_word();
    @(negedge clk);
    start = 1'b1; acc = 1'b0; base = AW'(100); len = AW'(6);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = w;
    #1 check("mid_rdy0", in_ready, 1);
    @(negedge clk);
    in_data = t;
    #1 check("mid_rdy1", in_ready, 1);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 check("rst_wen_drop", sram_wen, 1);
    @(negedge clk);
    #1 check_reset_outputs("midrst");
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_wr_count", log_wa.size(), 1);
    if (log_wa.size() >= 1) begin
      check("midrst_wr_addr", log_wa[0], 100);
      check("midrst_wr_data", log_wd[0], w);
    end
    for (int l = 0; l < COL; l++) ref_mem[100][l] = lane_of(w, l);

    // start and rd_req together: accumulate wins
    beat_q.delete();
    for (int k = 0; k < 3; k++) beat_q.push_back(rand_word());
    accum_pass(99, 3, 1'b1, 1'b0, 1'b1, run);
    drain_pass(99, 3, 1'b0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
